// File: rtl/mips_pkg.sv
// Shared MIPS decode definitions: opcode/funct constants, ALU codes,
// datapath select encodings and the decoded bundle carried through the queue.
package mips_pkg;

    // Primary opcodes (Inst_code[31:26])
    localparam logic [5:0] OP_R     = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_SLTIU = 6'b001011;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    // R-type function codes (Inst_code[5:0])
    localparam logic [5:0] F_ADD  = 6'b100000;
    localparam logic [5:0] F_SUB  = 6'b100010;
    localparam logic [5:0] F_AND  = 6'b100100;
    localparam logic [5:0] F_OR   = 6'b100101;
    localparam logic [5:0] F_XOR  = 6'b100110;
    localparam logic [5:0] F_NOR  = 6'b100111;
    localparam logic [5:0] F_SLTU = 6'b101011;
    localparam logic [5:0] F_SLLV = 6'b000100;

    typedef enum logic [2:0] {
        ALU_AND  = 3'b000,
        ALU_OR   = 3'b001,
        ALU_XOR  = 3'b010,
        ALU_NOR  = 3'b011,
        ALU_ADD  = 3'b100,
        ALU_SUB  = 3'b101,
        ALU_SLTU = 3'b110,
        ALU_SLLV = 3'b111
    } alu_op_e;

    typedef enum logic [1:0] {
        PC_PLUS4  = 2'b00,
        PC_BRANCH = 2'b01,
        PC_JUMP   = 2'b10
    } pc_s_e;

    typedef enum logic [1:0] {
        WREG_RD = 2'b00,
        WREG_RT = 2'b01
    } w_r_s_e;

    typedef enum logic [1:0] {
        WD_ALU = 2'b00,
        WD_MEM = 2'b01
    } wr_data_s_e;

    // One decoded instruction as stored in a queue entry
    typedef struct packed {
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [15:0] imm_offset;
        logic [25:0] address;
        logic        rt_imm_s;
        logic        imm_s;
        wr_data_s_e  wr_data_s;
        logic        mem_write;
        logic        write_reg;
        w_r_s_e      w_r_s;
        pc_s_e       pc_s;
        alu_op_e     alu_op;
        logic        illegal;
    } bundle_t;

endpackage

// File: rtl/mips_decode_queue_if.sv
// Fetch-side push handshake, execute-side pop handshake and head bundle fields.
interface mips_decode_queue_if #(
    parameter int DEPTH    = 4,
    parameter int ALU_OP_W = 3,
    parameter int CNT_W    = $clog2(DEPTH) + 1
);
    logic                flush;
    logic                in_valid;
    logic                in_ready;
    logic [31:0]         Inst_code;
    logic                out_valid;
    logic                out_ready;
    logic [4:0]          rs;
    logic [4:0]          rt;
    logic [4:0]          rd;
    logic [15:0]         imm_offset;
    logic [25:0]         address;
    logic                rt_imm_s;
    logic                imm_s;
    logic [1:0]          wr_data_s;
    logic                Mem_Write;
    logic                Write_Reg;
    logic [1:0]          w_r_s;
    logic [1:0]          PC_s;
    logic [ALU_OP_W-1:0] ALU_OP;
    logic                illegal;
    logic [CNT_W-1:0]    level;

    // Pipeline side driving fetch and execute handshakes
    modport master (
        output flush, in_valid, Inst_code, out_ready,
        input  in_ready, out_valid, rs, rt, rd, imm_offset, address, rt_imm_s,
               imm_s, wr_data_s, Mem_Write, Write_Reg, w_r_s, PC_s, ALU_OP,
               illegal, level
    );

    // Decode queue side
    modport slave (
        input  flush, in_valid, Inst_code, out_ready,
        output in_ready, out_valid, rs, rt, rd, imm_offset, address, rt_imm_s,
               imm_s, wr_data_s, Mem_Write, Write_Reg, w_r_s, PC_s, ALU_OP,
               illegal, level
    );
endinterface

// File: rtl/mips_decode_comb.sv
// Pure combinational decode of one 32-bit instruction into a bundle.
// Unsupported opcodes/functs raise illegal with all side-effect controls off.
module mips_decode_comb
    import mips_pkg::*;
(
    input  logic [31:0] inst_code,
    output bundle_t     bundle
);
    logic [5:0] op;
    logic [5:0] func;

    assign op   = inst_code[31:26];
    assign func = inst_code[5:0];

    // Controls default to zero; fields are always raw slices
    always_comb begin
        bundle            = '0;
        bundle.rs         = inst_code[25:21];
        bundle.rt         = inst_code[20:16];
        bundle.rd         = inst_code[15:11];
        bundle.imm_offset = inst_code[15:0];
        bundle.address    = inst_code[25:0];
        case (op)
            OP_R: begin
                bundle.write_reg = 1'b1;
                case (func)
                    F_ADD:   bundle.alu_op = ALU_ADD;
                    F_SUB:   bundle.alu_op = ALU_SUB;
                    F_AND:   bundle.alu_op = ALU_AND;
                    F_OR:    bundle.alu_op = ALU_OR;
                    F_XOR:   bundle.alu_op = ALU_XOR;
                    F_NOR:   bundle.alu_op = ALU_NOR;
                    F_SLTU:  bundle.alu_op = ALU_SLTU;
                    F_SLLV:  bundle.alu_op = ALU_SLLV;
                    default: begin
                        bundle.illegal   = 1'b1;
                        bundle.write_reg = 1'b0;
                    end
                endcase
            end
            OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_SLTIU: begin
                bundle.rt_imm_s  = 1'b1;
                bundle.w_r_s     = WREG_RT;
                bundle.write_reg = 1'b1;
                case (op)
                    OP_ADDI:  begin bundle.alu_op = ALU_ADD;  bundle.imm_s = 1'b1; end
                    OP_ANDI:  bundle.alu_op = ALU_AND;
                    OP_ORI:   bundle.alu_op = ALU_OR;
                    OP_XORI:  bundle.alu_op = ALU_XOR;
                    default:  begin bundle.alu_op = ALU_SLTU; bundle.imm_s = 1'b1; end
                endcase
            end
            OP_LW: begin
                bundle.alu_op    = ALU_ADD;
                bundle.rt_imm_s  = 1'b1;
                bundle.imm_s     = 1'b1;
                bundle.wr_data_s = WD_MEM;
                bundle.w_r_s     = WREG_RT;
                bundle.write_reg = 1'b1;
            end
            OP_SW: begin
                bundle.alu_op    = ALU_ADD;
                bundle.rt_imm_s  = 1'b1;
                bundle.imm_s     = 1'b1;
                bundle.mem_write = 1'b1;
            end
            OP_BEQ: begin
                bundle.alu_op = ALU_SUB;
                bundle.imm_s  = 1'b1;
                bundle.pc_s   = PC_BRANCH;
            end
            OP_J: begin
                bundle.pc_s = PC_JUMP;
            end
            default: begin
                bundle.illegal = 1'b1;
            end
        endcase
    end
endmodule

// File: rtl/mips_decode_queue.sv
// Registered decoder with a DEPTH-entry queue of decoded bundles.
// The head is held in its own register so fields stay stable when empty.
module mips_decode_queue
    import mips_pkg::*;
#(
    parameter int DEPTH    = 4,
    parameter int ALU_OP_W = 3,
    parameter int CNT_W    = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    mips_decode_queue_if.slave bus
);
    localparam int IDX_W = $clog2(DEPTH);

    bundle_t          decoded;
    bundle_t          mem [DEPTH];
    bundle_t          head_reg;
    bundle_t          head_next;
    logic [CNT_W-1:0] wr_ptr_reg;
    logic [CNT_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] wr_ptr_next;
    logic [CNT_W-1:0] rd_ptr_next;
    logic [CNT_W-1:0] level;
    logic [CNT_W-1:0] level_next;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;

    mips_decode_comb u_decode (
        .inst_code (bus.Inst_code),
        .bundle    (decoded)
    );

    assign level = wr_ptr_reg - rd_ptr_reg;
    assign full  = (level == CNT_W'(DEPTH));
    assign empty = (level == '0);
    assign push  = bus.in_valid && !full && !bus.flush;
    assign pop   = bus.out_ready && !empty && !bus.flush;

    // Next pointers and the bundle that will sit at the head after this edge
    always_comb begin
        wr_ptr_next = wr_ptr_reg + CNT_W'(push);
        rd_ptr_next = bus.flush ? wr_ptr_reg : rd_ptr_reg + CNT_W'(pop);
        level_next  = wr_ptr_next - rd_ptr_next;
        head_next   = head_reg;
        if (level_next != '0) begin
            // Head lands on the slot being written only when everything older is gone
            if (push && (rd_ptr_next[IDX_W-1:0] == wr_ptr_reg[IDX_W-1:0]))
                head_next = decoded;
            else
                head_next = mem[rd_ptr_next[IDX_W-1:0]];
        end
    end

    // Pointer and head state, cleared immediately on reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            head_reg   <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            head_reg   <= head_next;
        end
    end

    // Entry storage, no reset needed since pointers gate validity
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr_reg[IDX_W-1:0]] <= decoded;
    end

    assign bus.in_ready   = !full;
    assign bus.out_valid  = !empty;
    assign bus.level      = level;
    assign bus.rs         = head_reg.rs;
    assign bus.rt         = head_reg.rt;
    assign bus.rd         = head_reg.rd;
    assign bus.imm_offset = head_reg.imm_offset;
    assign bus.address    = head_reg.address;
    assign bus.rt_imm_s   = head_reg.rt_imm_s;
    assign bus.imm_s      = head_reg.imm_s;
    assign bus.wr_data_s  = head_reg.wr_data_s;
    assign bus.Mem_Write  = head_reg.mem_write;
    assign bus.Write_Reg  = head_reg.write_reg;
    assign bus.w_r_s      = head_reg.w_r_s;
    assign bus.PC_s       = head_reg.pc_s;
    assign bus.ALU_OP     = ALU_OP_W'(head_reg.alu_op);
    assign bus.illegal    = head_reg.illegal;
endmodule
